gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_checker.sv | 127 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustively sweeps the four input vectors of a 2-input
// gate under test, lets each vector settle, samples the response and compares
// it against an expected truth table.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request one sweep (accepted only in IDLE)
//   a, b       registered stimulus = vector index {MSB, LSB}
//   y          response from the gate under test
//   busy       high while driving/sampling vectors
//   done       one-cycle completion pulse
//   pass       last completed sweep had no mismatches
//   err_cnt    mismatch count of the current/last sweep (0..4)
//   fail_mask  bit i set when vector i mismatched
module gate_sweep_checker #(
  parameter logic [3:0]  EXP_TABLE   = 4'b0111,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        ERR_MAX   = 3'd4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [HOLD_W-1:0] hold, hold_d;
  logic [2:0]        err_d;
  logic [3:0]        mask_d;
  logic              pass_d, done_d, busy_d;

  // Stimulus comes straight from the vector index register.
  assign a = idx[1];
  assign b = idx[0];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    hold_d  = hold;
    err_d   = err_cnt;
    mask_d  = fail_mask;
    pass_d  = pass;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        hold_d = hold + HOLD_W'(1);
        if (hold == HOLD_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (y != EXP_TABLE[idx]) begin
          if (err_cnt != ERR_MAX) err_d = err_cnt + 3'd1;
          mask_d[idx] = 1'b1;
        end
        if (idx != IDX_W'(3)) begin
          idx_d   = idx + IDX_W'(1);
          hold_d  = '0;
          state_d = DRIVE;
        end else begin
          // Pass includes the final compare made on this edge.
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      hold      <= '0;
      err_cnt   <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      hold      <= hold_d;
      err_cnt   <= err_d;
      fail_mask <= mask_d;
      pass      <= pass_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

  typedef struct packed {
    logic a;
    logic b;
    logic busy;
    logic done;
  } cyc_t;

  typedef struct packed {
    logic       pass;
    logic [2:0] err;
    logic [3:0] mask;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;

  cyc_t exp_q[$];
  res_t res_q[$];

  logic start0, start1;
  logic a0, b0, y0, busy0, done0, pass0;
  logic a1, b1, y1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;

  logic oa, ob, obusy, odone, opass;
  logic [2:0] oerr;
  logic [3:0] omask;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  // Gate models: 0 = NAND, 1 = stuck-at-0, 2 = AND.
  function automatic logic gate(input int m, input logic ga, input logic gb);
    case (m)
      0:       gate = ~(ga & gb);
      1:       gate = 1'b0;
      default: gate = ga & gb;
    endcase
  endfunction

  always_comb y0 = gate(mode, a0, b0);
  always_comb y1 = gate(mode, a1, b1);

  assign oa    = sel ? a1    : a0;
  assign ob    = sel ? b1    : b0;
  assign obusy = sel ? busy1 : busy0;
  assign odone = sel ? done1 : done0;
  assign opass = sel ? pass1 : pass0;
  assign oerr  = sel ? err1  : err0;
  assign omask = sel ? mask1 : mask0;

  gate_sweep_checker dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_mask(mask0)
  );

  gate_sweep_checker #(.EXP_TABLE(4'b0111), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1)
  );

  function automatic res_t model_result(input int m);
    res_t r;
    logic [1:0] v;
    logic ex;
    r = '{pass: 1'b1, err: 3'd0, mask: 4'd0};
    for (int i = 0; i < 4; i++) begin
      v  = 2'(i);
      ex = ~(v[1] & v[0]);
      if (gate(m, v[1], v[0]) !== ex) begin
        r.err     = r.err + 3'd1;
        r.mask[i] = 1'b1;
        r.pass    = 1'b0;
      end
    end
    return r;
  endfunction

  // Expected per-cycle outputs, sample k taken just after edge k (edge 0 accepts start).
  task automatic push_sweep(input int hold);
    int n;
    logic [1:0] iv;
    cyc_t c;
    n = 4 * (hold + 1);
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) begin
        iv = 2'(k / (hold + 1));
        c  = '{a: iv[1], b: iv[0], busy: 1'b1, done: 1'b0};
      end else if (k == n) begin
        c = '{a: 1'b1, b: 1'b1, busy: 1'b0, done: 1'b1};
      end else begin
        c = '{a: 1'b1, b: 1'b1, busy: 1'b0, done: 1'b0};
      end
      exp_q.push_back(c);
    end
  endtask

  task automatic run_sweep(input int hold, input int m, input bit restart);
    int n;
    cyc_t e, got;
    res_t r, gr;
    n = 4 * (hold + 1);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    push_sweep(hold);
    res_q.push_back(model_result(m));
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      if (k > 0) begin
        if (restart && (k == 3 || k == 12)) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      e   = exp_q.pop_front();
      got = '{a: oa, b: ob, busy: obusy, done: odone};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cycle h=%0d m=%0d k=%0d {a,b,busy,done} got %b exp %b", hold, m, k, got, e);
      end
      if (k == 0) begin
        gr = '{pass: opass, err: oerr, mask: omask};
        checks++;
        if (gr !== 8'b0) begin
          errors++;
          $display("FAIL clear_at_accept h=%0d m=%0d got %b exp %b", hold, m, gr, 8'b0);
        end
      end
      if (k == n) begin
        r  = res_q.pop_front();
        gr = '{pass: opass, err: oerr, mask: omask};
        checks++;
        if (gr !== r) begin
          errors++;
          $display("FAIL result h=%0d m=%0d {pass,err,mask} got %b exp %b", hold, m, gr, r);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'b0) begin
      errors++;
      $display("FAIL reset_dut0 got %b exp %b", {a0, b0, busy0, done0, pass0, err0, mask0}, 12'b0);
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, mask1} !== 12'b0) begin
      errors++;
      $display("FAIL reset_dut1 got %b exp %b", {a1, b1, busy1, done1, pass1, err1, mask1}, 12'b0);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nand();
    run_sweep(4, 0, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_stuck0();
    run_sweep(4, 1, 1'b0);
  endtask

  task automatic test_and();
    run_sweep(4, 2, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_sweep(4, 0, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'b0) begin
      errors++;
      $display("FAIL reset_mid got %b exp %b", {a0, b0, busy0, done0, pass0, err0, mask0}, 12'b0);
    end
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done0 || busy0) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d exp %0d", dones, 0);
    end
    run_sweep(4, 0, 1'b0);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    run_sweep(4, 0, 1'b0);
    run_sweep(4, 1, 1'b0);
    repeat (2) @(posedge clk);
    sel = 1'b1;
    run_sweep(1, 0, 1'b0);
    run_sweep(1, 1, 1'b0);
    run_sweep(1, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nand();
    test_stuck0();
    test_and();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
